// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC command pins, instruction-memory req/ack, decoder valid/ready and redirect.
// master = instr_fetch, slave = its environment (PC, memory, decoder, execute).
interface instr_fetch_if #(
  parameter int AW = 14,
  parameter int IW = 19
);
  logic          loadPC;
  logic          incPC;
  logic [AW-1:0] pc_address;
  logic [AW-1:0] execadd;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;
  logic          ir_valid;
  logic [IW-1:0] ir_data;
  logic [AW-1:0] ir_pc;
  logic          ir_ready;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          fetch_err;

  modport master (
    output loadPC, incPC, pc_address, mem_req, mem_addr, ir_valid, ir_data, ir_pc, fetch_err,
    input  execadd, mem_ack, mem_rdata, ir_ready, redirect, redirect_addr
  );

  modport slave (
    input  loadPC, incPC, pc_address, mem_req, mem_addr, ir_valid, ir_data, ir_pc, fetch_err,
    output execadd, mem_ack, mem_rdata, ir_ready, redirect, redirect_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: commands the PC, reads the word at execadd and hands it to the decoder.
// Optional fetch timeout with sticky fetch_err is enabled by defining INSTR_FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int AW = 14,
  parameter int IW = 19,
`ifdef INSTR_FETCH_TIMEOUT_EN
  parameter int TIMEOUT = 255,
`endif
  parameter int SETTLE_CYC = 2
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);
  localparam int CW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {S_SETTLE, S_FETCH, S_FULL, S_DRAIN} state_e;

  // {loadPC, incPC} encodings understood by the PC
  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_INC   = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_HOLD  = 2'b11;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [AW-1:0] pc_address_q, pc_address_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          ir_valid_q, ir_valid_d;
  logic [IW-1:0] ir_data_q, ir_data_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;

`ifdef INSTR_FETCH_TIMEOUT_EN
  logic [7:0] to_q, to_d;
  logic       err_q, err_d;
  logic       waiting, timed_out;

  always_comb begin
    waiting   = (state_q == S_FETCH) || (state_q == S_DRAIN);
    timed_out = waiting && !bus.mem_ack && (to_q >= 8'(TIMEOUT - 1));
    to_d      = (waiting && !bus.mem_ack && !timed_out) ? to_q + 8'd1 : 8'd0;
    err_d     = err_q | (timed_out && !bus.redirect);
  end
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = CMD_HOLD;
    pc_address_d = pc_address_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    ir_valid_d   = ir_valid_q;
    ir_data_d    = ir_data_q;
    ir_pc_d      = ir_pc_q;

    if (bus.redirect) begin
      cmd_d        = CMD_LOAD;
      pc_address_d = bus.redirect_addr;
    end

    unique case (state_q)
      S_SETTLE: begin
        if (bus.redirect) begin
          cnt_d = CW'(SETTLE_CYC);
        end else if (cnt_q == '0) begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = bus.execadd;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FETCH: begin
        if (bus.redirect) begin
          // The word in flight belongs to the old stream: drop it now or drain it later.
          if (bus.mem_ack) begin
            mem_req_d = 1'b0;
            cnt_d     = CW'(SETTLE_CYC);
            state_d   = S_SETTLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (bus.mem_ack) begin
          ir_data_d  = bus.mem_rdata;
          ir_pc_d    = mem_addr_q;
          ir_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = S_FULL;
        end
      end
      S_FULL: begin
        if (bus.redirect) begin
          ir_valid_d = 1'b0;
          cnt_d      = CW'(SETTLE_CYC);
          state_d    = S_SETTLE;
        end else if (bus.ir_ready) begin
          ir_valid_d = 1'b0;
          cmd_d      = CMD_INC;
          cnt_d      = CW'(SETTLE_CYC);
          state_d    = S_SETTLE;
        end
      end
      S_DRAIN: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = CW'(SETTLE_CYC);
          state_d   = S_SETTLE;
        end
      end
      default: state_d = S_SETTLE;
    endcase

`ifdef INSTR_FETCH_TIMEOUT_EN
    // Give up on the memory: clear the PC so fetching restarts from address 0.
    if (timed_out && !bus.redirect) begin
      cmd_d     = CMD_CLEAR;
      mem_req_d = 1'b0;
      cnt_d     = CW'(SETTLE_CYC);
      state_d   = S_SETTLE;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_SETTLE;
      cnt_q        <= CW'(SETTLE_CYC);
      cmd_q        <= CMD_CLEAR;
      pc_address_q <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      ir_valid_q   <= 1'b0;
      ir_data_q    <= '0;
      ir_pc_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      pc_address_q <= pc_address_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      ir_valid_q   <= ir_valid_d;
      ir_data_q    <= ir_data_d;
      ir_pc_q      <= ir_pc_d;
    end
  end

`ifdef INSTR_FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign bus.fetch_err = err_q;
`else
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.loadPC     = cmd_q[1];
  assign bus.incPC      = cmd_q[0];
  assign bus.pc_address = pc_address_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.ir_valid   = ir_valid_q;
  assign bus.ir_data    = ir_data_q;
  assign bus.ir_pc      = ir_pc_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a two-register PC model and a variable-latency memory model.
// Build with INSTR_FETCH_TIMEOUT_EN defined to also exercise the fetch timeout (TIMEOUT=8).
module tb_instr_fetch;
  localparam int AW = 14;
  localparam int IW = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.AW(AW), .IW(IW)) bus ();

  instr_fetch #(
    .AW(AW),
    .IW(IW),
`ifdef INSTR_FETCH_TIMEOUT_EN
    .TIMEOUT(8),
`endif
    .SETTLE_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // memory model controls
  int            mem_lat   = 0;
  bit            mem_en    = 1'b1;
  bit            mem_fixed = 1'b0;
  logic [IW-1:0] mem_fixed_data = '0;
  int            mem_wait  = 0;

  // PC model: PC register then execadd output register (two cycles of settle)
  logic [AW-1:0] pc_q = '0;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return (a == '0) ? 19'h1A2B3 : {5'h0A, a};
  endfunction

  function automatic logic [1:0] cmd();
    return {bus.loadPC, bus.incPC};
  endfunction

  initial begin
    bus.execadd = '0;
    forever begin
      @(posedge clk);
      bus.execadd <= pc_q;
      case ({bus.loadPC, bus.incPC})
        2'b00:   pc_q <= '0;
        2'b10:   pc_q <= bus.pc_address;
        2'b01:   pc_q <= pc_q + 14'd1;
        default: ;
      endcase
    end
  end

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1 && mem_en) begin
        if (mem_wait >= mem_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_fixed ? mem_fixed_data : mem_word(bus.mem_addr);
          mem_wait      = 0;
        end else begin
          mem_wait++;
        end
      end else begin
        mem_wait = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name, input int limit);
    int n = 0;
    tick();
    while (bus.mem_req !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    total++;
    if (bus.mem_req !== 1'b1) begin
      bad++;
      $display("FAIL %s: mem_req=%b, wanted 1 within %0d cycles", name, bus.mem_req, limit);
    end
  endtask

  task automatic wait_valid(input string name, input int limit);
    int n = 0;
    while (bus.ir_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    total++;
    if (bus.ir_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s: ir_valid=%b, wanted 1 within %0d cycles", name, bus.ir_valid, limit);
    end
  endtask

  task automatic test_reset();
    mem_lat = 0; mem_en = 1'b1; mem_fixed = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (cmd() !== 2'b00 || bus.mem_req !== 1'b0 || bus.ir_valid !== 1'b0 || bus.mem_addr !== '0 ||
        bus.ir_data !== '0 || bus.ir_pc !== '0 || bus.pc_address !== '0 || bus.fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: cmd=%b req=%b valid=%b addr=%h data=%h pc=%h pcadr=%h err=%b, wanted 00/0/0/0/0/0/0/0",
               cmd(), bus.mem_req, bus.ir_valid, bus.mem_addr, bus.ir_data, bus.ir_pc, bus.pc_address, bus.fetch_err);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (bus.mem_req !== 1'b0 || cmd() !== 2'b11) begin
        bad++;
        $display("FAIL settle_%0d: req=%b cmd=%b, wanted 0/11", i, bus.mem_req, cmd());
      end
    end
    tick();
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 14'h0) begin
      bad++;
      $display("FAIL first_req: req=%b addr=%h, wanted 1/0000", bus.mem_req, bus.mem_addr);
    end
    tick();
    total++;
    if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 14'h0 || bus.ir_data !== 19'h1A2B3 || bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL first_word: valid=%b pc=%h data=%h req=%b, wanted 1/0000/1a2b3/0",
               bus.ir_valid, bus.ir_pc, bus.ir_data, bus.mem_req);
    end
  endtask

  task automatic test_stream();
    int rises = 0, acc = 0, incs = 0, odd = 0;
    logic prev_req = 1'b0;
    logic [AW-1:0] seen [4];
    mem_lat = 3; mem_en = 1'b1; ir_ready_set(1'b1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 200 && rises < 4; c++) begin
      tick();
      if (cmd() === 2'b01) incs++;
      else if (cmd() !== 2'b11) odd++;
      if (bus.ir_valid === 1'b1) begin
        total++;
        if (bus.ir_pc !== 14'(acc) || bus.ir_data !== mem_word(14'(acc))) begin
          bad++;
          $display("FAIL stream_word_%0d: pc=%h data=%h, wanted %h/%h", acc, bus.ir_pc, bus.ir_data,
                   14'(acc), mem_word(14'(acc)));
        end
        acc++;
      end
      if (bus.mem_req === 1'b1 && prev_req !== 1'b1) begin
        seen[rises] = bus.mem_addr;
        rises++;
      end
      prev_req = bus.mem_req;
    end
    total++;
    if (rises != 4) begin
      bad++;
      $display("FAIL stream_reqs: saw %0d requests, wanted 4", rises);
    end
    for (int k = 0; k < rises; k++) begin
      total++;
      if (seen[k] !== 14'(k)) begin
        bad++;
        $display("FAIL stream_addr_%0d: mem_addr=%h, wanted %h", k, seen[k], 14'(k));
      end
    end
    total++;
    if (incs != 3 || odd != 0) begin
      bad++;
      $display("FAIL stream_cmds: inc pulses=%0d other=%0d, wanted 3/0", incs, odd);
    end
  endtask

  task automatic ir_ready_set(input logic v);
    bus.ir_ready = v;
  endtask

  task automatic test_stall();
    logic [IW-1:0] d0;
    logic [AW-1:0] p0;
    ir_ready_set(1'b0);
    wait_valid("stall_valid", 20);
    d0 = bus.ir_data;
    p0 = bus.ir_pc;
    total++;
    if (p0 !== 14'h3 || d0 !== mem_word(14'h3)) begin
      bad++;
      $display("FAIL stall_word: pc=%h data=%h, wanted 0003/%h", p0, d0, mem_word(14'h3));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (bus.ir_valid !== 1'b1 || bus.ir_data !== d0 || bus.ir_pc !== p0 || bus.mem_req !== 1'b0 || cmd() !== 2'b11) begin
        bad++;
        $display("FAIL stall_cycle_%0d: valid=%b data=%h pc=%h req=%b cmd=%b, wanted 1/%h/%h/0/11",
                 i, bus.ir_valid, bus.ir_data, bus.ir_pc, bus.mem_req, cmd(), d0, p0);
      end
    end
    ir_ready_set(1'b1);
    tick();
    ir_ready_set(1'b0);
    total++;
    if (cmd() !== 2'b01 || bus.ir_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: cmd=%b valid=%b, wanted 01/0", cmd(), bus.ir_valid);
    end
  endtask

  task automatic test_redirect_fetch();
    int loads = 0;
    bit leaked = 1'b0, rose = 1'b0;
    logic prev_req = 1'b1;
    mem_en = 1'b0;
    wait_req("rf_req", 10);
    total++;
    if (bus.mem_addr !== 14'h4) begin
      bad++;
      $display("FAIL rf_addr: mem_addr=%h, wanted 0004", bus.mem_addr);
    end
    bus.redirect = 1'b1; bus.redirect_addr = 14'h0100;
    tick();
    bus.redirect = 1'b0;
    total++;
    if (cmd() !== 2'b10 || bus.pc_address !== 14'h0100 || bus.mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rf_load: cmd=%b pc_address=%h req=%b, wanted 10/0100/1", cmd(), bus.pc_address, bus.mem_req);
    end
    mem_fixed = 1'b1; mem_fixed_data = 19'h7FFFF; mem_lat = 3; mem_en = 1'b1;
    for (int c = 0; c < 40 && !rose; c++) begin
      tick();
      if (cmd() === 2'b10) loads++;
      if (bus.ir_valid !== 1'b0 || bus.ir_data === 19'h7FFFF) leaked = 1'b1;
      if (bus.mem_req === 1'b1 && prev_req !== 1'b1) rose = 1'b1;
      prev_req = bus.mem_req;
    end
    mem_fixed = 1'b0;
    total++;
    if (!rose || bus.mem_addr !== 14'h0100 || loads != 0 || leaked) begin
      bad++;
      $display("FAIL rf_refetch: rose=%b addr=%h extra_loads=%0d leaked=%b, wanted 1/0100/0/0",
               rose, bus.mem_addr, loads, leaked);
    end
    wait_valid("rf_valid", 20);
    total++;
    if (bus.ir_pc !== 14'h0100 || bus.ir_data !== mem_word(14'h0100)) begin
      bad++;
      $display("FAIL rf_word: pc=%h data=%h, wanted 0100/%h", bus.ir_pc, bus.ir_data, mem_word(14'h0100));
    end
  endtask

  task automatic test_redirect_full();
    int incs = 0;
    bit rose = 1'b0;
    logic prev_req = 1'b0;
    mem_lat = 0;
    bus.redirect = 1'b1; bus.redirect_addr = 14'h0005;
    tick();
    bus.redirect = 1'b0;
    total++;
    if (cmd() !== 2'b10 || bus.ir_valid !== 1'b0) begin
      bad++;
      $display("FAIL rfull_drop: cmd=%b valid=%b, wanted 10/0", cmd(), bus.ir_valid);
    end
    wait_valid("rfull_valid5", 20);
    total++;
    if (bus.ir_pc !== 14'h0005 || bus.ir_data !== mem_word(14'h0005)) begin
      bad++;
      $display("FAIL rfull_word5: pc=%h data=%h, wanted 0005/%h", bus.ir_pc, bus.ir_data, mem_word(14'h0005));
    end
    ir_ready_set(1'b1);
    bus.redirect = 1'b1; bus.redirect_addr = 14'h0040;
    tick();
    bus.redirect = 1'b0;
    ir_ready_set(1'b0);
    total++;
    if (cmd() !== 2'b10 || bus.ir_valid !== 1'b0 || bus.pc_address !== 14'h0040) begin
      bad++;
      $display("FAIL rfull_both: cmd=%b valid=%b pc_address=%h, wanted 10/0/0040", cmd(), bus.ir_valid, bus.pc_address);
    end
    for (int c = 0; c < 20 && !rose; c++) begin
      tick();
      if (cmd() === 2'b01) incs++;
      if (bus.mem_req === 1'b1 && prev_req !== 1'b1) rose = 1'b1;
      prev_req = bus.mem_req;
    end
    total++;
    if (!rose || bus.mem_addr !== 14'h0040 || incs != 0) begin
      bad++;
      $display("FAIL rfull_refetch: rose=%b addr=%h inc pulses=%0d, wanted 1/0040/0", rose, bus.mem_addr, incs);
    end
    tick();
    total++;
    if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 14'h0040) begin
      bad++;
      $display("FAIL rfull_word40: valid=%b pc=%h, wanted 1/0040", bus.ir_valid, bus.ir_pc);
    end
  endtask

`ifdef INSTR_FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int highs = 1;
    mem_en = 1'b0; mem_lat = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++;
    if (bus.fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL to_clear: fetch_err=%b, wanted 0", bus.fetch_err);
    end
    bus.redirect = 1'b1; bus.redirect_addr = 14'h0123;
    tick();
    bus.redirect = 1'b0;
    wait_req("to_req", 10);
    total++;
    if (bus.mem_addr !== 14'h0123) begin
      bad++;
      $display("FAIL to_addr: mem_addr=%h, wanted 0123", bus.mem_addr);
    end
    for (int c = 0; c < 50; c++) begin
      tick();
      if (bus.mem_req !== 1'b1) break;
      highs++;
    end
    total++;
    if (highs != 8 || cmd() !== 2'b00 || bus.fetch_err !== 1'b1) begin
      bad++;
      $display("FAIL to_fire: req cycles=%0d cmd=%b err=%b, wanted 8/00/1", highs, cmd(), bus.fetch_err);
    end
    mem_en = 1'b1;
    wait_req("to_refetch_req", 10);
    total++;
    if (bus.mem_addr !== 14'h0 || bus.fetch_err !== 1'b1) begin
      bad++;
      $display("FAIL to_refetch: addr=%h err=%b, wanted 0000/1", bus.mem_addr, bus.fetch_err);
    end
    tick();
    total++;
    if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 14'h0 || bus.fetch_err !== 1'b1) begin
      bad++;
      $display("FAIL to_sticky: valid=%b pc=%h err=%b, wanted 1/0000/1", bus.ir_valid, bus.ir_pc, bus.fetch_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL to_rst: fetch_err=%b, wanted 0", bus.fetch_err);
    end
  endtask
`endif

  initial begin
    bus.ir_ready      = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_fetch();
    test_redirect_full();
`ifdef INSTR_FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
